fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_1000, is the address of the first fetched instruction after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of instruction-buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  Single clock; all state updates on rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 imem_addr  output  32  Byte address to instruction memory; equals the current PC.
REQ-006 imem_rdata  input  32  Little-endian word returned combinationally by instruction memory for imem_addr in the same cycle.
REQ-007 instr  output  32  Instruction at buffer head.
REQ-008 instr_pc  output  32  PC of instr.
REQ-009 instr_valid  output  1  Buffer head holds a valid instruction.
REQ-010 instr_ready  input  1  Decode accepts head this cycle.
REQ-011 redirect_valid  input  1  Branch/jump redirect request, one-cycle pulse.
REQ-012 redirect_pc  input  32  Redirect target address.
REQ-013 misalign  output  1  Misaligned-redirect flag; present only when FETCH_MISALIGN_TRAP_EN is defined.

Function
REQ-014 The block SHALL hold a 32-bit PC register, a BUF_DEPTH-entry FIFO of {pc, instr} pairs, and an entry count.
REQ-015 imem_addr SHALL equal the PC register combinationally at all times.
REQ-016 Enqueue SHALL occur when the registered count < BUF_DEPTH, no redirect is active, and the block is not halted; it writes {PC, imem_rdata} at the tail, and PC <= PC + 4 (modulo 2^32, wrapping from 32'hFFFF_FFFC to 0).
REQ-017 When the registered count == BUF_DEPTH, the block SHALL hold the PC and SHALL NOT enqueue, even if a dequeue occurs in the same cycle; this avoids a combinational path from instr_ready.
REQ-018 Dequeue SHALL occur when instr_valid && instr_ready; the head pointer advances.
REQ-019 A simultaneous enqueue and dequeue SHALL leave the count unchanged.
REQ-020 instr_valid SHALL equal (count != 0); instr and instr_pc SHALL be driven from the head entry and held stable while instr_valid && !instr_ready.
REQ-021 redirect_valid SHALL take priority over enqueue and dequeue in the same cycle:
- FIFO flushed (count = 0);
- PC <= redirect_pc;
- no enqueue that cycle;
- instr_valid low in the following cycle;
- the target instruction is enqueued in the cycle after the redirect.
REQ-022 Latency: the first instruction SHALL appear with instr_valid = 1 one rising edge after reset deassertion; after a redirect, the target SHALL appear two edges after the redirect edge.
REQ-023 Pointers SHALL wrap modulo BUF_DEPTH.
REQ-024 State machine:
- FETCH: normal operation.
- HALT: entered only via REQ-030.
- Leaves HALT only on a redirect with an aligned target.

Reset
REQ-025 Asserting reset SHALL asynchronously set PC = RESET_PC, count = 0, pointers = 0, state = FETCH, and misalign = 0.
REQ-026 During reset, instr_valid SHALL be 0 and instr and instr_pc SHALL be 0.
REQ-027 Reset asserted mid-stream SHALL discard all buffered entries; no partial entry survives.

Configuration
REQ-028 The macro FETCH_MISALIGN_TRAP_EN SHALL control misaligned-redirect handling.
REQ-029 Without the macro, bits [1:0] of redirect_pc SHALL be forced to 0 and the misalign port SHALL be absent.
REQ-030 With the macro, a redirect with redirect_pc[1:0] != 0 SHALL:
- flush the FIFO;
- set misalign = 1;
- enter HALT, with no enqueues and PC = redirect_pc.
REQ-031 With the macro, a later aligned redirect SHALL clear misalign and return the block to FETCH.

Structure
REQ-032 Package fetch_pkg SHALL hold XLEN = 32, the RESET_PC default, the instruction width, the state enum {FETCH, HALT}, and a packed fetch_entry_t struct {pc, instr}.
REQ-033 Sub-module fetch_fifo SHALL hold the FIFO storage and pointers; fetch_unit holds the PC, the state machine, and redirect logic.

Verification
REQ-034 Memory loaded at 0x1000..0x1010 with FFC4A303, 0064A423, 0062E233, FDA48393, FE420AE3; reset released, instr_ready = 1 -> the pairs (1000, FFC4A303) ... (1010, FE420AE3) appear on consecutive cycles.
REQ-035 instr_ready = 0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 0x1008, and the head stays (1000, FFC4A303); instr_ready = 1 -> the stream resumes in order with no drop or duplicate.
REQ-036 redirect_valid pulse with redirect_pc = 0x1004 while the FIFO is full and instr_ready = 1 -> instr_valid = 0 next cycle, then (1004, 0064A423) is presented.
REQ-037 reset asserted asynchronously mid-cycle with 2 entries buffered -> instr_valid drops immediately; after release, fetch restarts at 0x1000.
REQ-038 PC = 32'hFFFF_FFFC -> the next imem_addr is 0x0000_0000.
REQ-039 With the macro, a redirect to 0x1006 -> misalign = 1 and no valid instructions; then a redirect to 0x1008 -> misalign = 0 and (1008, 0062E233) is presented.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch slice:
//   XLEN / ILEN       : address and instruction widths
//   RESET_PC_DEFAULT  : default address of the first fetched instruction
//   fetch_state_e     : fetch state machine encoding {FETCH, HALT}
//   fetch_entry_t     : one instruction-buffer entry {pc, instr}
//   pc_align()        : clears the byte-offset bits of an address
// Optional feature macro used by the slice: FETCH_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_1000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Instruction buffer: DEPTH-entry FIFO of {pc, instr} pairs with head/tail
// pointers and an occupancy count. DEPTH must be a power of two (2 or 4)
// so the pointers wrap naturally.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   flush_i        : discard all entries (takes priority over enq/deq)
//   enq_i          : write enq_entry_i at the tail
//   enq_entry_i    : entry to write
//   deq_i          : advance the head
//   head_o         : head entry, all-zero while empty
//   full_o         : count == DEPTH
//   empty_o        : count == 0
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         enq_i,
    input  fetch_entry_t enq_entry_i,
    input  logic         deq_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];

    // Next-state for pointers and count; flush wins over enqueue/dequeue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (enq_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_i, deq_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so no stale entry can ever surface.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enq_i && !flush_i) begin
            mem_q[wr_ptr_q] <= enq_entry_i;
        end
    end

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == {CW{1'b0}});
    // Present zeros while empty so instr/instr_pc read 0 in and after reset.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetch: owns the PC, the FETCH/HALT state machine and
// redirect handling, and feeds a fetch_fifo instruction buffer.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   imem_addr       : byte address to instruction memory (= PC)
//   imem_rdata      : word returned combinationally for imem_addr
//   instr/instr_pc  : buffer head instruction and its PC
//   instr_valid     : buffer head is valid
//   instr_ready     : decode accepts the head this cycle
//   redirect_valid  : one-cycle redirect request
//   redirect_pc     : redirect target
//   misalign        : misaligned-redirect flag (only with FETCH_MISALIGN_TRAP_EN)
// Configuration macro: FETCH_MISALIGN_TRAP_EN. When undefined, redirect
// targets are forced word aligned and the block never halts.
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    logic [XLEN-1:0] pc_q, pc_d;
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] redirect_tgt_s;
    logic            enq_s;
    logic            deq_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    fetch_entry_t    enq_entry_s;
    fetch_entry_t    head_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
    logic            redirect_misaligned_s;

    assign redirect_tgt_s        = redirect_pc;
    assign redirect_misaligned_s = (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_tgt_s        = pc_align(redirect_pc);
`endif

    // Enqueue decision uses only registered fullness, never instr_ready, so
    // a full buffer stalls for one cycle even when the head is consumed.
    assign enq_s = !fifo_full_s && !redirect_valid && (state_q == FETCH);
    assign deq_s = !fifo_empty_s && instr_ready && !redirect_valid;

    assign enq_entry_s = '{pc: pc_q, instr: imem_rdata};

    // PC next-state: redirect beats sequential advance; +4 wraps at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_tgt_s;
        end else if (enq_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // HALT on a misaligned redirect; any aligned redirect returns to FETCH.
    always_comb begin
        state_d    = state_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            if (redirect_misaligned_s) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                state_d    = FETCH;
                misalign_d = 1'b0;
            end
        end else begin
            state_d    = state_q;
            misalign_d = misalign_q;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    // Without the trap feature there is no way into HALT.
    always_comb begin
        state_d = FETCH;
    end
`endif

    // PC and state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .enq_i       (enq_s),
        .enq_entry_i (enq_entry_s),
        .deq_i       (deq_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign imem_addr   = pc_q;
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;
    assign instr_valid = !fifo_empty_s;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit (BUF_DEPTH = 2) plus short
// hand-written sequences for asynchronous reset, PC wrap and redirect
// alignment / misalign trap (FETCH_MISALIGN_TRAP_EN).
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .RESET_PC  (32'h0000_1000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model: program words at 0x1000..0x1010, an
    // address-derived pattern everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hFFC4_A303;
            32'h0000_1004: return 32'h0064_A423;
            32'h0000_1008: return 32'h0062_E233;
            32'h0000_100C: return 32'hFDA4_8393;
            32'h0000_1010: return 32'hFE42_0AE3;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_valid, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [31:0] e_addr);
        chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
        chk({tag, ".pc"},    instr_pc,  e_pc);
        chk({tag, ".instr"}, instr,     e_instr);
        chk({tag, ".addr"},  imem_addr, e_addr);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [20];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Streaming from reset with decode always ready.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      32'h0,          32'h1000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1000,   32'hFFC4_A303,  32'h1004};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1004,   32'h0064_A423,  32'h1008};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1008,   32'h0062_E233,  32'h100C};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h100C,   32'hFDA4_8393,  32'h1010};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1010,   32'hFE42_0AE3,  32'h1014};
        // Reset, then decode stalled for 5 cycles: buffer saturates at 2.
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      32'h0,          32'h1000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      32'h0,          32'h1000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h1000,   32'hFFC4_A303,  32'h1004};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h1000,   32'hFFC4_A303,  32'h1008};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h1000,   32'hFFC4_A303,  32'h1008};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h1000,   32'hFFC4_A303,  32'h1008};
        // Resume: full buffer does not enqueue on the draining cycle.
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1000,   32'hFFC4_A303,  32'h1008};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1004,   32'h0064_A423,  32'h1008};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1008,   32'h0062_E233,  32'h100C};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h100C,   32'hFDA4_8393,  32'h1010};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h100C,   32'hFDA4_8393,  32'h1014};
        // Redirect to 0x1004 while full and ready.
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h1004,   1'b1, 32'h100C,   32'hFDA4_8393,  32'h1014};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      32'h0,          32'h1004};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1004,   32'h0064_A423,  32'h1008};

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            instr_ready    = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                    vecs[i].e_instr, vecs[i].e_addr);
        end

        // Asynchronous reset mid-cycle with two entries buffered.
        @(negedge clk);
        reset       = 1'b1;
        instr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_out("fill2", 1'b1, 32'h1000, 32'hFFC4_A303, 32'h1008);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 32'h0, 32'h1000);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("async_rst.misalign", {31'b0, misalign}, 32'h0);
`endif
        @(negedge clk);
        reset       = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        #1;
        chk_out("restart", 1'b1, 32'h1000, 32'hFFC4_A303, 32'h1004);

        // PC wrap from 0xFFFF_FFFC to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_out("wrap0", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk_out("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0000_0000);
        @(negedge clk);
        #1;
        chk_out("wrap2", 1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0004);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect halts fetch; an aligned one resumes it.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1006;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("mis.flag", {31'b0, misalign}, 32'h1);
        chk_out("mis0", 1'b0, 32'h0, 32'h0, 32'h1006);
        @(negedge clk);
        #1;
        chk_out("mis1", 1'b0, 32'h0, 32'h0, 32'h1006);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1008;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("mis.clear", {31'b0, misalign}, 32'h0);
        chk_out("mis2", 1'b0, 32'h0, 32'h0, 32'h1008);
`else
        // Low address bits of a redirect target are dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100A;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_out("align0", 1'b0, 32'h0, 32'h0, 32'h1008);
`endif
        @(negedge clk);
        #1;
        chk_out("redir_tgt", 1'b1, 32'h1008, 32'h0062_E233, 32'h100C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
